// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with synchroniser, parity, framing and break detection
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int CNT_W       = 15,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic [CNT_W-1:0]     br_clocks,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_dv,
  output logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, per;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic perr_q, ferr_q, ones_q;
  logic rxs, mid, bit_end, last_data, last_stop, done, ferr_n;
  assign rxs = sync[SYNC_STAGES-1];
  assign mid = cnt == (per >> 1) - CNT_W'(1);
  assign bit_end = cnt == per - CNT_W'(1);
  assign last_data = bcnt == 4'(DATA_BITS - 1);
  assign last_stop = bcnt == 4'(STOP_BITS - 1);
  assign done = state == STOP && bit_end && last_stop;
  assign ferr_n = ferr_q | ~rxs;
  // next-state selection; frame errors park in WAIT_HIGH so a held break is decoded once
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rxs ? IDLE : START;
      START:     state_n = mid ? (rxs ? IDLE : DATA) : START;
      DATA:      state_n = bit_end && last_data ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:    state_n = bit_end ? STOP : PARITY;
      STOP:      state_n = done ? (ferr_n ? WAIT_HIGH : IDLE) : STOP;
      WAIT_HIGH: state_n = rxs ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // synchroniser, divisor latch, bit timing, shifting and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      cnt <= '0;
      per <= '0;
      bcnt <= '0;
      shreg <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ones_q <= 1'b0;
      rx_data <= '0;
      rx_dv <= 1'b0;
      rx_ready <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_serial};
      rx_dv <= done;
      rx_ready <= state_n == IDLE;
      if (state == IDLE) per <= br_clocks < CNT_W'(4) ? CNT_W'(4) : br_clocks;
      cnt <= (state inside {IDLE, WAIT_HIGH} || state_n != state || bit_end) ? '0 : cnt + CNT_W'(1);
      bcnt <= state_n != state ? 4'd0 : bcnt + 4'(bit_end);
      if (state == START) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
        ones_q <= 1'b0;
      end
      if (bit_end && state inside {DATA, PARITY, STOP}) ones_q <= ones_q | rxs;
      if (state == DATA && bit_end) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      if (state == PARITY && bit_end) perr_q <= ((^shreg) ^ rxs) != 1'(PARITY_ODD);
      if (state == STOP && bit_end) ferr_q <= ferr_n;
      if (done) begin
        rx_data <= shreg;
        parity_err <= perr_q;
        frame_err <= ferr_n;
        break_det <= ~(ones_q | rxs);
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed table-driven bench for an 8N1 receiver and an 8E2 receiver
module tb_uart_rx_cfg;
  logic clk = 1'b0, rst = 1'b1, rxa = 1'b1, rxb = 1'b1;
  logic [14:0] br_clocks = 15'd16;
  logic [7:0] data_a, data_b;
  logic dv_a, dv_b, rdy_a, rdy_b, pe_a, pe_b, fe_a, fe_b, bk_a, bk_b;
  int checks = 0, failures = 0;
  int n_a = 0, n_b = 0;
  logic [7:0] last_a = 0, prev_a = 0;
  logic rdv_a = 0, rdv_b = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx_serial(rxa), .br_clocks(br_clocks), .rx_data(data_a), .rx_dv(dv_a),
    .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a));
  uart_rx_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx_serial(rxb), .br_clocks(br_clocks), .rx_data(data_b), .rx_dv(dv_b),
    .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b));

  // count every cycle rx_dv is high and remember what was delivered with it
  always @(negedge clk) begin
    if (dv_a) begin
      n_a = n_a + 1;
      prev_a = last_a;
      last_a = data_a;
      rdv_a = rdy_a;
    end
    if (dv_b) begin
      n_b = n_b + 1;
      rdv_b = rdy_b;
    end
  end

  typedef struct {
    int d;
    logic [7:0] data;
    logic pbit;
    logic [1:0] stops;
    int br;
    int bl;
    logic [7:0] exp_data;
    logic exp_pe, exp_fe, exp_bk;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic b, input int n);
    if (d == 0) rxa = b;
    else rxb = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic pbit, input logic [1:0] stops, input int bl);
    drive(d, 1'b0, bl);
    for (int i = 0; i < 8; i++) drive(d, data[i], bl);
    if (d == 1) drive(d, pbit, bl);
    drive(d, stops[0], bl);
    if (d == 1) drive(d, stops[1], bl);
    drive(d, 1'b1, 0);
  endtask

  initial begin
    int na, nb;
    v[0] = '{0, 8'hA5, 1'b0, 2'b11, 16, 16, 8'hA5, 1'b0, 1'b0, 1'b0};
    v[1] = '{1, 8'h3C, 1'b1, 2'b11, 16, 16, 8'h3C, 1'b1, 1'b0, 1'b0};
    v[2] = '{1, 8'h3C, 1'b0, 2'b11, 16, 16, 8'h3C, 1'b0, 1'b0, 1'b0};
    v[3] = '{1, 8'h55, 1'b0, 2'b01, 16, 16, 8'h55, 1'b0, 1'b1, 1'b0};
    v[4] = '{0, 8'hC3, 1'b0, 2'b11, 2, 4, 8'hC3, 1'b0, 1'b0, 1'b0};
    v[5] = '{1, 8'h00, 1'b0, 2'b00, 16, 16, 8'h00, 1'b0, 1'b1, 1'b1};
    v[6] = '{1, 8'h00, 1'b1, 2'b00, 16, 16, 8'h00, 1'b1, 1'b1, 1'b0};
    v[7] = '{0, 8'hFF, 1'b0, 2'b11, 8, 8, 8'hFF, 1'b0, 1'b0, 1'b0};
    v[8] = '{1, 8'h81, 1'b0, 2'b11, 10, 10, 8'h81, 1'b0, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    chk("reset_outputs_a", {data_a, dv_a, rdy_a, pe_a, fe_a, bk_a}, 0);
    chk("reset_outputs_b", {data_b, dv_b, rdy_b, pe_b, fe_b, bk_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {rdy_a, rdy_b}, 2'b11);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      br_clocks = 15'(v[i].br);
      repeat (3) @(negedge clk);
      na = n_a;
      nb = n_b;
      send(v[i].d, v[i].data, v[i].pbit, v[i].stops, v[i].bl);
      repeat (3 * v[i].bl + 8) @(negedge clk);
      chk($sformatf("v%0d_dv_count", i), v[i].d == 0 ? n_a - na : n_b - nb, 1);
      chk($sformatf("v%0d_data", i), v[i].d == 0 ? data_a : data_b, v[i].exp_data);
      chk($sformatf("v%0d_parity_err", i), v[i].d == 0 ? pe_a : pe_b, v[i].exp_pe);
      chk($sformatf("v%0d_frame_err", i), v[i].d == 0 ? fe_a : fe_b, v[i].exp_fe);
      chk($sformatf("v%0d_break_det", i), v[i].d == 0 ? bk_a : bk_b, v[i].exp_bk);
      chk($sformatf("v%0d_ready_at_dv", i), v[i].d == 0 ? rdv_a : rdv_b, !v[i].exp_fe);
      chk($sformatf("v%0d_ready_after", i), v[i].d == 0 ? rdy_a : rdy_b, 1);
      chk($sformatf("v%0d_other_quiet", i), v[i].d == 0 ? n_b - nb : n_a - na, 0);
    end

    br_clocks = 15'd16;
    repeat (3) @(negedge clk);
    na = n_a;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    chk("glitch_no_dv", n_a - na, 0);
    chk("glitch_ready", rdy_a, 1);

    na = n_a;
    drive(0, 1'b0, 20 * 16);
    drive(0, 1'b1, 48);
    chk("break_dv_count", n_a - na, 1);
    chk("break_data", data_a, 0);
    chk("break_flags", {pe_a, fe_a, bk_a}, 3'b011);
    send(0, 8'h12, 1'b0, 2'b11, 16);
    repeat (56) @(negedge clk);
    chk("after_break_dv_count", n_a - na, 2);
    chk("after_break_data", data_a, 8'h12);
    chk("after_break_flags", {pe_a, fe_a, bk_a}, 0);

    na = n_a;
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_outputs", {data_a, dv_a, rdy_a, pe_a, fe_a, bk_a}, 0);
    rxa = 1'b1;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midframe_reset_no_dv", n_a - na, 0);
    chk("midframe_reset_ready", rdy_a, 1);

    na = n_a;
    fork
      send(0, 8'h96, 1'b0, 2'b11, 16);
      begin
        repeat (50) @(negedge clk);
        br_clocks = 15'd8;
      end
    join
    repeat (56) @(negedge clk);
    send(0, 8'hE7, 1'b0, 2'b11, 8);
    repeat (32) @(negedge clk);
    chk("br_change_dv_count", n_a - na, 2);
    chk("br_change_first", prev_a, 8'h96);
    chk("br_change_second", last_a, 8'hE7);

    br_clocks = 15'd16;
    repeat (3) @(negedge clk);
    na = n_a;
    send(0, 8'h81, 1'b0, 2'b11, 16);
    send(0, 8'h7E, 1'b0, 2'b11, 16);
    repeat (56) @(negedge clk);
    chk("b2b_dv_count", n_a - na, 2);
    chk("b2b_first", prev_a, 8'h81);
    chk("b2b_second", last_a, 8'h7E);
    chk("b2b_flags", {pe_a, fe_a, bk_a}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
